sample_mixer: RTL and testbench
===============================

// Module: sample_mixer
// PURPOSE
//  Upstream feeder of the PWM output stage. Once per PWM frame, scans NUM_VOICES
//  8-bit unsigned voice samples, sums the enabled ones and normalises to 8 bits.
//  Presents the result on sample with a 1-cycle done strobe; the PWM stage latches it.
//  Frame timing comes from an internal period counter matching the PWM 255-step frame.
// PARAMETERS
//  NUM_VOICES  4    voices mixed; power of 2, 2..8
//  PERIOD      255  clk cycles per output sample; must be >= NUM_VOICES+3
// PORTS
//  clk          in   1             system clock, rising edge
//  rst          in   1             asynchronous, active-high reset
//  en           in   1             1 = period counter runs; 0 = counter frozen
//  voice_active in   NUM_VOICES    per-voice enable mask; 0 = voice contributes 0
//  voice_data   in   8             unsigned sample of voice selected by voice_sel (comb, same cycle)
//  voice_sel    out  clog2(NUM_VOICES)  index of voice being read
//  sample       out  8             mixed sample, held between updates
//  done         out  1             1-cycle strobe: sample updated this cycle
// BEHAVIOUR
//  Reset (async, rst=1): period count=1, FSM=IDLE, acc=0, voice_sel=0, sample=0, done=0.
//  Period counter: if en, count = (count==PERIOD) ? 1 : count+1; else hold.
//  tick = en && count==PERIOD && state==IDLE; a tick outside IDLE is dropped (cannot occur if PERIOD legal).
//  FSM, tick in cycle T:
//   IDLE  -> ACCUM on tick; acc<=0, voice_sel<=0.
//   ACCUM  cycles T+1..T+NUM_VOICES: acc += voice_active[voice_sel] ? voice_data : 0;
//          voice_sel increments; after index NUM_VOICES-1 -> NORM, voice_sel<=0.
//   NORM   cycle T+NUM_VOICES+1: compute norm from acc (see CONFIGURATION) -> DONE.
//   DONE   cycle T+NUM_VOICES+2: sample=norm, done=1 this cycle only -> IDLE.
//  Latency tick->done = NUM_VOICES+2 cycles (6 at default); done period = PERIOD cycles.
//  acc width 8+clog2(NUM_VOICES) bits; no overflow possible.
//  voice_active sampled per voice during its ACCUM cycle; mid-frame mask changes affect only unread voices.
//  en deasserted mid-frame: FSM completes the frame and emits done; only the counter freezes.
//  rst mid-frame: frame aborted, no done, sample returns to 0.
//  sample changes only in the DONE cycle; done never asserted two consecutive cycles.
// CONFIGURATION
//  MIXER_SAT_EN undefined: norm = acc >> clog2(NUM_VOICES) (average, never clips).
//  MIXER_SAT_EN defined:   norm = (acc > 255) ? 8'd255 : acc[7:0] (sum, saturating).
//  All other behaviour identical in both builds.
// TESTING
//  1 rst pulse mid-ACCUM -> sample=0, done=0, voice_sel=0 immediately (async); no done that frame.
//  2 en=1 from reset, all voices 0 -> done every 255 cycles, first 6 cycles after count hits 255; sample=0.
//  3 voices 200,100,50,10, mask 4'b1111 -> sample=90 (avg); MIXER_SAT_EN build -> 255.
//  4 mask 4'b0001, voice0=200 -> sample=50; MIXER_SAT_EN build -> 200.
//  5 en dropped at tick+2 -> done still at tick+6; no further done until en=1 and count reaches 255.
//  6 all voices 255, mask 4'b1111 -> sample=255 both builds; sample held unchanged between done strobes.

Source files
------------

// File: rtl/sample_mixer.sv
// sample_mixer
//   Once per PWM frame, reads NUM_VOICES 8-bit unsigned voice samples one at a
//   time and sums the enabled ones. It then normalises the sum to 8 bits and
//   presents the result on sample with a one-cycle done strobe.
//   Frame timing comes from an internal 1..PERIOD counter that runs while en=1.
//
// Build option
//   MIXER_SAT_EN  undefined: sample = sum >> clog2(NUM_VOICES)  (average)
//                 defined:   sample = min(sum, 255)             (saturating sum)
//
// Ports
//   clk           in   system clock, rising edge
//   rst           in   asynchronous, active-high reset
//   en            in   1 = period counter runs, 0 = counter frozen
//   voice_active  in   per-voice enable mask
//   voice_data    in   sample of the voice selected by voice_sel (same cycle)
//   voice_sel     out  index of the voice being read
//   sample        out  mixed sample, held between updates
//   done          out  1-cycle strobe, sample updated this cycle
module sample_mixer #(
    parameter int NUM_VOICES = 4,
    parameter int PERIOD     = 255
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          en,
    input  logic [NUM_VOICES-1:0]         voice_active,
    input  logic [7:0]                    voice_data,
    output logic [$clog2(NUM_VOICES)-1:0] voice_sel,
    output logic [7:0]                    sample,
    output logic                          done
);
    localparam int SW = $clog2(NUM_VOICES);
    localparam int AW = 8 + SW;            // holds NUM_VOICES*255 exactly
    localparam int CW = $clog2(PERIOD + 1);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] ACCUM = 2'd1;
    localparam logic [1:0] NORM  = 2'd2;
    localparam logic [1:0] DONE  = 2'd3;

    logic [CW-1:0] count;
    logic [1:0]    state;
    logic [AW-1:0] acc;
    logic [AW-1:0] addend;
    logic [7:0]    norm;
    logic          tick;

    // Period counter runs 1..PERIOD regardless of the mixing FSM.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= CW'(1);
        end else if (en) begin
            count <= (count == CW'(PERIOD)) ? CW'(1) : count + CW'(1);
        end
    end

    // A tick outside IDLE is simply ignored.
    assign tick = en && (count == CW'(PERIOD)) && (state == IDLE);

    assign addend = voice_active[voice_sel] ? AW'(voice_data) : '0;

    always_comb begin
        norm = '0;
`ifdef MIXER_SAT_EN
        norm = (acc > AW'(255)) ? 8'd255 : acc[7:0];
`else
        norm = acc[AW-1:SW];
`endif
    end

    // sample is loaded on the edge leaving NORM so it first appears, together
    // with done, in the DONE cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            acc       <= '0;
            voice_sel <= '0;
            sample    <= '0;
            done      <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (tick) begin
                        state     <= ACCUM;
                        acc       <= '0;
                        voice_sel <= '0;
                    end
                end
                ACCUM: begin
                    acc <= acc + addend;
                    if (voice_sel == SW'(NUM_VOICES - 1)) begin
                        voice_sel <= '0;
                        state     <= NORM;
                    end else begin
                        voice_sel <= voice_sel + SW'(1);
                    end
                end
                NORM: begin
                    sample <= norm;
                    done   <= 1'b1;
                    state  <= DONE;
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_sample_mixer.sv
// tb_sample_mixer
//   Randomised and directed stimulus for sample_mixer. A per-cycle reference
//   model predicts every done strobe and the sample value from frame arithmetic.
//   It checks done and sample on every cycle.
module tb_sample_mixer;
    localparam int NUM_VOICES = 4;
    localparam int PERIOD     = 255;
    localparam int SW         = $clog2(NUM_VOICES);
    localparam int LAT        = NUM_VOICES + 2;

    logic                  clk = 1'b0;
    logic                  rst = 1'b1;
    logic                  en  = 1'b0;
    logic [NUM_VOICES-1:0] voice_active = '0;
    logic [7:0]            voice_data;
    logic [SW-1:0]         voice_sel;
    logic [7:0]            sample;
    logic                  done;

    logic [7:0] voices [NUM_VOICES];

    int checks = 0;
    int errors = 0;

    sample_mixer #(.NUM_VOICES(NUM_VOICES), .PERIOD(PERIOD)) dut (
        .clk(clk), .rst(rst), .en(en), .voice_active(voice_active),
        .voice_data(voice_data), .voice_sel(voice_sel),
        .sample(sample), .done(done)
    );

    always #5 clk = ~clk;

    assign voice_data = voices[voice_sel];

    task automatic chk(input string tag, input int obs, input int exp);
        checks++;
        if (obs != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // Expected mix of the current voices/mask.
    function automatic int mix();
        int sum = 0;
        for (int i = 0; i < NUM_VOICES; i++)
            if (voice_active[i]) sum += voices[i];
`ifdef MIXER_SAT_EN
        return (sum > 255) ? 255 : sum;
`else
        return sum / NUM_VOICES;
`endif
    endfunction

    // Reference model: k counts enabled clock edges since reset, so the
    // counter shows PERIOD when k mod PERIOD == PERIOD-1.
    int k = 0, cyc = 0, due = -1, pend = 0, exp_sample = 0;
    bit tick_flag = 0;

    always @(negedge clk) begin
        bit is_done;
        cyc++;
        tick_flag = 0;
        if (rst) begin
            k = 0; due = -1; exp_sample = 0;
        end else begin
            if (en && (k % PERIOD) == PERIOD - 1 && due < 0) begin
                due = cyc + LAT;
                pend = mix();
                tick_flag = 1;
            end
            is_done = (due >= 0) && (cyc == due);
            if (is_done) exp_sample = pend;
            chk("done", int'(done), int'(is_done));
            chk("sample", int'(sample), exp_sample);
            if (is_done) due = -1;
            if (en) k++;
        end
    end

    task automatic wait_done(input string tag, input int bound, output int n);
        n = 0;
        while (1) begin
            @(negedge clk); #1;
            if (done) break;
            n++;
            if (n >= bound) begin
                chk({tag, "_timeout"}, 0, 1);
                break;
            end
        end
    endtask

    task automatic wait_tick();
        int n = 0;
        while (!tick_flag && n < 600) begin
            @(negedge clk); #1;
            n++;
        end
        if (!tick_flag) chk("tick_timeout", 0, 1);
    endtask

    task automatic set_voices(input int v0, input int v1, input int v2, input int v3,
                              input logic [NUM_VOICES-1:0] m);
        @(posedge clk); #1;
        voices[0] = 8'(v0); voices[1] = 8'(v1); voices[2] = 8'(v2); voices[3] = 8'(v3);
        voice_active = m;
    endtask

    initial begin
        int n;
        for (int i = 0; i < NUM_VOICES; i++) voices[i] = 8'd0;

        // Reset state
        #12;
        chk("rst_sample", int'(sample), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_sel", int'(voice_sel), 0);

        // All voices zero: first done PERIOD-1+LAT cycles after release, then every PERIOD
        voice_active = 4'b1111;
        @(posedge clk); #1;
        rst = 1'b0; en = 1'b1;
        wait_done("first", 600, n);
        chk("first_latency", n, PERIOD - 1 + LAT);
        chk("zero_sample", int'(sample), 0);
        wait_done("second", 600, n);
        chk("period", n + 1, PERIOD);

        // Full mix
        set_voices(200, 100, 50, 10, 4'b1111);
        wait_done("mix_all", 600, n);
`ifdef MIXER_SAT_EN
        chk("mix_all_val", int'(sample), 255);
`else
        chk("mix_all_val", int'(sample), 90);
`endif

        // Single voice
        set_voices(200, 77, 33, 11, 4'b0001);
        wait_done("mix_one", 600, n);
`ifdef MIXER_SAT_EN
        chk("mix_one_val", int'(sample), 200);
`else
        chk("mix_one_val", int'(sample), 50);
`endif

        // All full scale
        set_voices(255, 255, 255, 255, 4'b1111);
        wait_done("mix_max", 600, n);
        chk("mix_max_val", int'(sample), 255);

        // Async reset in the middle of ACCUM
        wait_tick();
        repeat (3) @(posedge clk);
        #3 rst = 1'b1;
        #1;
        chk("mid_rst_sample", int'(sample), 0);
        chk("mid_rst_done", int'(done), 0);
        chk("mid_rst_sel", int'(voice_sel), 0);
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        set_voices(10, 20, 30, 40, 4'b1010);
        wait_done("after_rst", 600, n);
        chk("after_rst_latency", n, PERIOD - 2 + LAT);

        // en dropped two cycles after the tick: frame still completes
        wait_tick();
        repeat (2) @(posedge clk);
        #1 en = 1'b0;
        wait_done("en_drop", 10, n);
        repeat (300) @(negedge clk);
        @(posedge clk); #1 en = 1'b1;
        wait_done("en_resume", 600, n);

        // Random frames
        for (int f = 0; f < 8; f++) begin
            @(posedge clk); #1;
            for (int i = 0; i < NUM_VOICES; i++) voices[i] = 8'($urandom_range(0, 255));
            voice_active = NUM_VOICES'($urandom);
            wait_done("rand", 600, n);
        end

        repeat (5) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
